// File: rtl/intc_timer_pkg.sv
// Shared constants for the interrupt controller: register addresses, source bit
// assignments and register-port widths.
package intc_timer_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] INTC_PENDING = 2'd0;
  localparam logic [ADDR_W-1:0] INTC_MASK    = 2'd1;
  localparam logic [ADDR_W-1:0] INTC_RELOAD  = 2'd2;
  localparam logic [ADDR_W-1:0] INTC_COUNT   = 2'd3;

  localparam int IRQ_TIMER   = 0;
  localparam int IRQ_PS2     = 1;
  localparam int IRQ_UART_RX = 2;

endpackage

// File: rtl/intc_timer_if.sv
// Register access port of the interrupt controller; mem drives it as master.
// Strobes are single-cycle, read data returns one cycle after reg_ren.
interface intc_timer_if;

  logic                               reg_ren;
  logic                               reg_wen;
  logic [intc_timer_pkg::ADDR_W-1:0]  reg_addr;
  logic [intc_timer_pkg::REG_W-1:0]   reg_wdata;
  logic [intc_timer_pkg::REG_W-1:0]   reg_rdata;

  modport master (
    output reg_ren, reg_wen, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_ren, reg_wen, reg_addr, reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/intc_timer_interval_timer.sv
// Down-counting interval timer: fires a combinational 1-cycle pulse on the tick that reloads.
// Zero latency from tick to fire; never stalls, a COUNT write overrides the tick.
module intc_timer_interval_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick_en,
  input  logic [TIMER_W-1:0] i_reload,
  input  logic               i_cnt_wen,
  input  logic [TIMER_W-1:0] i_cnt_wdat,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_fire
);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] w_count_n;

  // A zero reload disables the timer; count==0 and count==1 both reload so the period equals reload.
  always_comb begin
    w_count_n = r_count;
    o_fire    = 1'b0;
    if (i_cnt_wen) begin
      w_count_n = i_cnt_wdat;
    end else if (i_tick_en && (i_reload != '0)) begin
      if (r_count <= TIMER_W'(1)) begin
        w_count_n = i_reload;
        o_fire    = 1'b1;
      end else begin
        w_count_n = r_count - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_n;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/intc_timer.sv
// Interrupt controller: edge-detected sources latch into PENDING, CPU sees pending & mask.
// Interrupts and read data are registered (1 cycle); register port always accepts.
module intc_timer
  import intc_timer_pkg::*;
#(
  parameter int              NSRC     = 16,
  parameter int              TIMER_W  = 32,
  parameter logic [NSRC-1:0] RST_MASK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_tick_en,
  input  logic [NSRC-1:1] i_src,
  intc_timer_if.slave     bus,
  output logic [NSRC-1:0] o_interrupts
);

  logic [NSRC-1:1]    r_src_q;
  logic [NSRC-1:0]    r_pending;
  logic [NSRC-1:0]    r_mask;
  logic [TIMER_W-1:0] r_reload;
  logic [NSRC-1:0]    r_irq;
  logic [REG_W-1:0]   r_rdata;

  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_reload;
  logic               w_wr_count;
  logic               w_fire;
  logic [TIMER_W-1:0] w_count;
  logic [NSRC-1:0]    w_w1c;
  logic [NSRC-1:0]    w_event;
  logic [NSRC-1:0]    w_pending_n;
  logic [NSRC-1:0]    w_mask_n;
  logic [REG_W-1:0]   w_rd_dat;

  assign w_wr_pend   = bus.reg_wen && (bus.reg_addr == INTC_PENDING);
  assign w_wr_mask   = bus.reg_wen && (bus.reg_addr == INTC_MASK);
  assign w_wr_reload = bus.reg_wen && (bus.reg_addr == INTC_RELOAD);
  assign w_wr_count  = bus.reg_wen && (bus.reg_addr == INTC_COUNT);

  intc_timer_interval_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick_en  (i_tick_en),
    .i_reload   (r_reload),
    .i_cnt_wen  (w_wr_count),
    .i_cnt_wdat (bus.reg_wdata[TIMER_W-1:0]),
    .o_count    (w_count),
    .o_fire     (w_fire)
  );

  // Set wins over W1C so an event arriving during a clear is never lost.
  always_comb begin
    w_event            = '0;
    w_event[NSRC-1:1]  = i_src & ~r_src_q;
    w_event[IRQ_TIMER] = w_fire;
    w_w1c              = w_wr_pend ? bus.reg_wdata[NSRC-1:0] : '0;
    w_pending_n        = (r_pending & ~w_w1c) | w_event;
    w_mask_n           = w_wr_mask ? bus.reg_wdata[NSRC-1:0] : r_mask;
  end

  always_comb begin
    w_rd_dat = '0;
    case (bus.reg_addr)
      INTC_PENDING: w_rd_dat = REG_W'(r_pending);
      INTC_MASK:    w_rd_dat = REG_W'(r_mask);
      INTC_RELOAD:  w_rd_dat = REG_W'(r_reload);
      INTC_COUNT:   w_rd_dat = REG_W'(w_count);
      default:      w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_mask    <= RST_MASK;
      r_reload  <= '0;
      r_irq     <= '0;
      r_rdata   <= '0;
    end else begin
      r_src_q   <= i_src;
      r_pending <= w_pending_n;
      r_mask    <= w_mask_n;
      r_irq     <= w_pending_n & w_mask_n;
      if (w_wr_reload) begin
        r_reload <= bus.reg_wdata[TIMER_W-1:0];
      end
      if (bus.reg_ren) begin
        r_rdata <= w_rd_dat;
      end
    end
  end

  assign bus.reg_rdata = r_rdata;
  assign o_interrupts  = r_irq;

endmodule

// File: tb/tb_intc_timer.sv
// Scoreboarded bench: driver runs a behavioural model and queues expectations,
// monitor compares interrupts every cycle and read data after each read strobe.
module tb_intc_timer;
  import intc_timer_pkg::*;

  localparam logic [15:0] RMASK = 16'h00F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_tick = 1'b0;
  logic [15:1] tb_src = '0;
  logic [15:0] irq;

  intc_timer_if bus();

  intc_timer #(
    .NSRC     (16),
    .TIMER_W  (32),
    .RST_MASK (RMASK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick_en    (tb_tick),
    .i_src        (tb_src),
    .bus          (bus),
    .o_interrupts (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [15:0] q_irq[$];
  logic [31:0] q_rd[$];

  // Reference state: what software would observe in each register.
  logic [15:0] m_pend, m_mask;
  logic [31:0] m_reload, m_count;
  logic [15:1] m_prev_src;

  logic        g_tick = 1'b0;
  logic [15:1] g_src  = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = RMASK; m_reload = '0; m_count = '0; m_prev_src = '0;
  endtask

  task automatic model_step(input logic tick, input logic [15:1] s, input logic ren,
                            input logic wen, input logic [1:0] a, input logic [31:0] d);
    logic        fire;
    logic [15:0] ev;
    if (ren) begin
      case (a)
        2'd0: q_rd.push_back({16'h0, m_pend});
        2'd1: q_rd.push_back({16'h0, m_mask});
        2'd2: q_rd.push_back(m_reload);
        default: q_rd.push_back(m_count);
      endcase
    end
    fire = 1'b0;
    if (wen && a == 2'd3) m_count = d;
    else if (tick && m_reload != 0) begin
      if (m_count < 2) begin m_count = m_reload; fire = 1'b1; end
      else m_count = m_count - 1;
    end
    ev = {s & ~m_prev_src, fire};
    m_prev_src = s;
    if (wen && a == 2'd0) m_pend = m_pend & ~d[15:0];
    m_pend = m_pend | ev;
    if (wen && a == 2'd1) m_mask = d[15:0];
    if (wen && a == 2'd2) m_reload = d;
    q_irq.push_back(m_pend & m_mask);
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the effect visible.
  task automatic drive(input logic tick, input logic [15:1] s, input logic ren,
                       input logic wen, input logic [1:0] a, input logic [31:0] d);
    tb_tick = tick; tb_src = s;
    bus.reg_ren = ren; bus.reg_wen = wen; bus.reg_addr = a; bus.reg_wdata = d;
    model_step(tick, s, ren, wen, a, d);
    @(posedge clk); #1;
  endtask

  task automatic step();                          drive(g_tick, g_src, 1'b0, 1'b0, 2'd0, 32'h0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); drive(g_tick, g_src, 1'b0, 1'b1, a, d); endtask
  task automatic rd(input logic [1:0] a);         drive(g_tick, g_src, 1'b1, 1'b0, a, 32'h0); endtask

  task automatic do_reset();
    mon_en = 1'b0;
    q_irq.delete(); q_rd.delete();
    rst_n = 1'b0;
    tb_tick = 1'b0; tb_src = '0; g_tick = 1'b0; g_src = '0;
    bus.reg_ren = 1'b0; bus.reg_wen = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    #1;
    check("rst_irq", {16'h0, irq}, 32'h0);
    check("rst_rdata", bus.reg_rdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Cycles from one timer fire to the next, with a W1C right after the first fire.
  task automatic measure(input bit half, output int n);
    n = 0;
    while (!irq[0] && n < 40) begin
      if (half) g_tick = ~g_tick;
      step(); n++;
    end
    if (half) g_tick = ~g_tick;
    wr(INTC_PENDING, 32'h1);
    n = 1;
    while (!irq[0] && n < 40) begin
      if (half) g_tick = ~g_tick;
      step(); n++;
    end
  endtask

  // Monitor
  initial begin
    bit rd_seen;
    int n_pend;
    forever begin
      @(posedge clk);
      rd_seen = mon_en && bus.reg_ren;
      n_pend  = mon_en ? q_irq.size() : 0;
      @(negedge clk);
      if (mon_en) begin
        if (n_pend > 0) check("irq", {16'h0, irq}, {16'h0, q_irq.pop_front()});
        if (rd_seen) begin
          if (q_rd.size() > 0) check("rdata", bus.reg_rdata, q_rd.pop_front());
          else check("rdata_unexpected", bus.reg_rdata, 32'hDEAD_BEEF);
        end
      end
    end
  end

  initial begin
    int n;
    do_reset();
    rd(INTC_MASK);
    check("mask_rst", bus.reg_rdata, {16'h0, RMASK});

    // Edge detect and W1C
    wr(INTC_MASK, 32'h0002);
    g_src = 15'h0001; step();
    check("edge_irq", {16'h0, irq}, 32'h0002);
    repeat (9) step();
    wr(INTC_PENDING, 32'h0002);
    check("w1c_irq", {16'h0, irq}, 32'h0);
    repeat (3) step();
    check("held_once", {16'h0, irq}, 32'h0);
    g_src = '0; step();

    // Timer period, full and half tick rate
    wr(INTC_PENDING, 32'hFFFF);
    wr(INTC_MASK, 32'h1);
    wr(INTC_RELOAD, 32'd5);
    g_tick = 1'b1;
    measure(1'b0, n);
    check("period_full", n, 5);
    measure(1'b1, n);
    check("period_half", n, 10);
    g_tick = 1'b0;
    wr(INTC_RELOAD, 32'd0);
    wr(INTC_PENDING, 32'hFFFF);

    // Set/clear collision on bit 2
    wr(INTC_MASK, 32'h0004);
    g_src = 15'h0002; step();
    g_src = '0; step();
    g_src = 15'h0002; wr(INTC_PENDING, 32'h0004);
    check("collision", {16'h0, irq}, 32'h0004);
    g_src = '0;

    // Masked pending
    wr(INTC_PENDING, 32'hFFFF);
    wr(INTC_MASK, 32'h0);
    g_src = 15'h0004; step();
    g_src = '0; step();
    rd(INTC_PENDING);
    check("masked_pend", bus.reg_rdata, 32'h0008);
    check("masked_irq", {16'h0, irq}, 32'h0);
    wr(INTC_MASK, 32'h0008);
    check("unmask_irq", {16'h0, irq}, 32'h0008);

    // Timer frozen at reload 0, then COUNT write racing a tick
    wr(INTC_PENDING, 32'hFFFF);
    wr(INTC_MASK, 32'h1);
    wr(INTC_COUNT, 32'd3);
    g_tick = 1'b1;
    repeat (8) step();
    rd(INTC_COUNT);
    check("frozen_cnt", bus.reg_rdata, 32'd3);
    check("frozen_irq", {16'h0, irq}, 32'h0);
    wr(INTC_RELOAD, 32'd4);
    wr(INTC_COUNT, 32'd1);
    check("cnt_wr_nofire", {16'h0, irq}, 32'h0);
    step();
    check("cnt_wr_fire", {16'h0, irq}, 32'h0001);
    drive(g_tick, g_src, 1'b1, 1'b1, INTC_COUNT, 32'd9);
    check("rd_pre_write", bus.reg_rdata, 32'd4);

    // Random traffic, reset mid-run, more random traffic
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 300; i++) begin
        logic [1:0]  a;
        logic [31:0] d;
        logic        r, w;
        g_tick = 1'($urandom_range(0, 1));
        g_src  = g_src ^ 15'($urandom & $urandom & $urandom);
        a = 2'($urandom_range(0, 3));
        r = ($urandom_range(0, 2) == 0);
        w = ($urandom_range(0, 3) == 0);
        d = (a >= 2'd2) ? 32'($urandom_range(0, 9)) : $urandom;
        drive(g_tick, g_src, r, w, a, d);
      end
      if (k == 0) begin
        rd(INTC_RELOAD);
        do_reset();
        g_tick = 1'b1;
        repeat (5) step();
        rd(INTC_COUNT);
        check("post_rst_cnt", bus.reg_rdata, 32'd0);
        rd(INTC_MASK);
        check("post_rst_mask", bus.reg_rdata, {16'h0, RMASK});
      end
    end

    g_tick = 1'b0; g_src = '0;
    repeat (3) step();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
